// File: rtl/seg7_pkg.sv
// seg7_pkg: hex-to-segment decode and shared constants for the 7-segment scan driver
//   SEG7_OFF    - all segments dark (active-low pattern incl. DP)
//   SEG7_PHASES - phases per digit slot; phase 0 is the anti-ghosting blank guard
//   seg7_decode - 4-bit hex nibble to active-low g..a segments
package seg7_pkg;
    localparam logic [7:0] SEG7_OFF    = 8'hFF;
    localparam int         SEG7_PHASES = 16;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction
endpackage

// File: rtl/seg7_tick_gen.sv
// seg7_tick_gen: prescaler issuing a one-cycle TICK enable every CLK_DIV clocks
//   CLK    - system clock
//   IN_CLR - asynchronous active-low reset
//   TICK   - high for one clock every CLK_DIV clocks (always high when CLK_DIV = 1)
module seg7_tick_gen #(
    parameter int CLK_DIV = 50000
) (
    input  logic CLK,
    input  logic IN_CLR,
    output logic TICK
);
    localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] r_cnt;

    assign TICK = (r_cnt == LAST);

    always_ff @(posedge CLK or negedge IN_CLR) begin
        if (!IN_CLR) r_cnt <= '0;
        else         r_cnt <= TICK ? '0 : r_cnt + CW'(1);
    end
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed common-anode 7-segment scanner with double-buffered load
//   CLK     - system clock (rising edge)
//   IN_CLR  - asynchronous active-low reset
//   DATA    - hex nibbles, digit i = DATA[4i+3:4i]
//   DP      - per-digit decimal point request (1 = lit)
//   DIG_EN  - per-digit enable (0 = dark)
//   LOAD    - strobe capturing DATA/DP/DIG_EN into the pending buffer
//   BRIGHT  - brightness 0..15, present only when SEG7_BRIGHTNESS_EN is defined
//   PATTERN - active-low segments, bit7 = DP, bits6..0 = g..a
//   DIGIT   - active-high one-hot digit select (or zero)
//   FRAME   - one-clock pulse when the active buffer is (re)loaded at frame start
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLK_DIV    = 50000
) (
    input  logic                    CLK,
    input  logic                    IN_CLR,
    input  logic [4*NUM_DIGITS-1:0] DATA,
    input  logic [NUM_DIGITS-1:0]   DP,
    input  logic [NUM_DIGITS-1:0]   DIG_EN,
    input  logic                    LOAD,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [3:0]              BRIGHT,
`endif
    output logic [7:0]              PATTERN,
    output logic [NUM_DIGITS-1:0]   DIGIT,
    output logic                    FRAME
);
    localparam int            IW       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_DIGITS - 1);

    logic                    w_tick;
    logic                    w_wrap;
    logic                    w_frame_start;
    logic                    w_lit;
    logic [3:0]              w_nib;
    logic [3:0]              r_phase;
    logic [IW-1:0]           r_idx;
    logic [4*NUM_DIGITS-1:0] r_pend_data, r_act_data;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_act_dp;
    logic [NUM_DIGITS-1:0]   r_pend_en, r_act_en;
    logic                    r_pend_flag;
    logic [7:0]              r_pattern;
    logic [NUM_DIGITS-1:0]   r_digit;
    logic                    r_frame;

    seg7_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .CLK    (CLK),
        .IN_CLR (IN_CLR),
        .TICK   (w_tick)
    );

    assign w_wrap        = (r_phase == 4'(SEG7_PHASES - 1));
    assign w_frame_start = w_tick && w_wrap && (r_idx == LAST_IDX);
    assign w_nib         = r_act_data[{r_idx, 2'b00} +: 4];
`ifdef SEG7_BRIGHTNESS_EN
    assign w_lit = (r_phase != 4'd0) && r_act_en[r_idx] && (r_phase <= BRIGHT);
`else
    assign w_lit = (r_phase != 4'd0) && r_act_en[r_idx];
`endif

    always_ff @(posedge CLK or negedge IN_CLR) begin
        if (!IN_CLR) begin
            r_phase <= '0;
            r_idx   <= '0;
        end else if (w_tick) begin
            r_phase <= r_phase + 4'd1;
            if (w_wrap) r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
        end
    end

    // Transfer uses the old pending contents, so a LOAD landing on the frame
    // start is held back (flag kept set) until the following frame start.
    always_ff @(posedge CLK or negedge IN_CLR) begin
        if (!IN_CLR) begin
            r_pend_data <= '0;
            r_pend_dp   <= '0;
            r_pend_en   <= '0;
            r_pend_flag <= 1'b0;
            r_act_data  <= '0;
            r_act_dp    <= '0;
            r_act_en    <= '0;
        end else begin
            if (w_frame_start && r_pend_flag) begin
                r_act_data <= r_pend_data;
                r_act_dp   <= r_pend_dp;
                r_act_en   <= r_pend_en;
            end
            if (LOAD) begin
                r_pend_data <= DATA;
                r_pend_dp   <= DP;
                r_pend_en   <= DIG_EN;
                r_pend_flag <= 1'b1;
            end else if (w_frame_start) begin
                r_pend_flag <= 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge IN_CLR) begin
        if (!IN_CLR) begin
            r_pattern <= SEG7_OFF;
            r_digit   <= '0;
            r_frame   <= 1'b0;
        end else begin
            r_pattern <= w_lit ? {~r_act_dp[r_idx], seg7_decode(w_nib)} : SEG7_OFF;
            r_digit   <= w_lit ? NUM_DIGITS'(1) << r_idx : '0;
            r_frame   <= w_frame_start;
        end
    end

    assign PATTERN = r_pattern;
    assign DIGIT   = r_digit;
    assign FRAME   = r_frame;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized + directed bench against a time-arithmetic display model
`timescale 1ns/1ps
module tb_seg7_scan_driver;
    localparam int N    = 4;
    localparam int DIV  = 2;
    localparam int FCLK = 16 * N * DIV;

    logic        CLK    = 1'b0;
    logic        IN_CLR = 1'b0;
    logic        LOAD   = 1'b0;
    logic [15:0] DATA   = '0;
    logic [3:0]  DP     = '0;
    logic [3:0]  DIG_EN = '0;
`ifdef SEG7_BRIGHTNESS_EN
    logic [3:0]  BRIGHT = 4'd15;
`endif
    logic [7:0]  PATTERN;
    logic [3:0]  DIGIT;
    logic        FRAME;

    int n_cmp = 0;
    int n_bad = 0;

    seg7_scan_driver #(.NUM_DIGITS(N), .CLK_DIV(DIV)) dut (
        .CLK     (CLK),
        .IN_CLR  (IN_CLR),
        .DATA    (DATA),
        .DP      (DP),
        .DIG_EN  (DIG_EN),
        .LOAD    (LOAD),
`ifdef SEG7_BRIGHTNESS_EN
        .BRIGHT  (BRIGHT),
`endif
        .PATTERN (PATTERN),
        .DIGIT   (DIGIT),
        .FRAME   (FRAME)
    );

    always #5 CLK = ~CLK;

    // Model: the display position is pure arithmetic on clocks since reset release.
    logic [6:0]  seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [15:0] m_pd, m_ad;
    logic [3:0]  m_pp, m_ap, m_pe, m_ae;
    bit          m_flag;
    int          k;
    logic [7:0]  e_pat = 8'hFF;
    logic [3:0]  e_dig = '0;
    logic        e_frm = 1'b0;

    always @(posedge CLK or negedge IN_CLR) begin
        if (!IN_CLR) begin
            k = 0;
            m_pd = '0; m_ad = '0; m_pp = '0; m_ap = '0; m_pe = '0; m_ae = '0;
            m_flag = 1'b0;
            e_pat = 8'hFF; e_dig = '0; e_frm = 1'b0;
        end else begin
            int t, ph, ix;
            bit lit;
            t   = k / DIV;
            ph  = t % 16;
            ix  = (t / 16) % N;
            lit = (ph != 0) && m_ae[ix];
`ifdef SEG7_BRIGHTNESS_EN
            lit = lit && (ph <= int'(BRIGHT));
`endif
            e_pat = lit ? {~m_ap[ix], seg_tab[m_ad[ix*4 +: 4]]} : 8'hFF;
            e_dig = lit ? 4'(1 << ix) : 4'd0;
            k++;
            e_frm = (k % FCLK) == 0;
            if (e_frm && m_flag) begin
                m_ad = m_pd; m_ap = m_pp; m_ae = m_pe;
            end
            if (LOAD) begin
                m_pd = DATA; m_pp = DP; m_pe = DIG_EN; m_flag = 1'b1;
            end else if (e_frm) begin
                m_flag = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        chk("pattern", PATTERN, e_pat);
        chk("digit", 8'(DIGIT), 8'(e_dig));
        chk("frame", 8'(FRAME), 8'(e_frm));
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic wait_frame();
        bit got = 1'b0;
        for (int i = 0; i < 2 * FCLK && !got; i++) begin
            @(negedge CLK);
            got = FRAME;
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_frame: no FRAME within %0d clocks", 2 * FCLK);
        end
    endtask

    task automatic wait_digit(input logic [3:0] d);
        bit got = 1'b0;
        for (int i = 0; i < 2 * FCLK && !got; i++) begin
            @(negedge CLK);
            got = (DIGIT == d);
        end
        if (!got) begin
            n_cmp++; n_bad++;
            $display("FAIL wait_digit: DIGIT never became %b", d);
        end
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p, input logic [3:0] e);
        DATA = d; DP = p; DIG_EN = e; LOAD = 1'b1;
        @(negedge CLK);
        LOAD = 1'b0;
    endtask

    initial begin
        int p;
        IN_CLR = 1'b0;
        cyc(10);
        chk("rst_pattern", PATTERN, 8'hFF);
        chk("rst_digit", 8'(DIGIT), 8'h00);
        chk("rst_frame", 8'(FRAME), 8'h00);
        IN_CLR = 1'b1;
        cyc(256);
        chk("dark_digit", 8'(DIGIT), 8'h00);

        load(16'h1234, 4'b0001, 4'hF);
        wait_frame();
        cyc(1);  chk("guard_pat", PATTERN, 8'hFF);
        cyc(2);  chk("d0_pat", PATTERN, 8'h19); chk("d0_dig", 8'(DIGIT), 8'h01);
        cyc(32); chk("d1_pat", PATTERN, 8'hB0); chk("d1_dig", 8'(DIGIT), 8'h02);
        cyc(32); chk("d2_pat", PATTERN, 8'hA4); chk("d2_dig", 8'(DIGIT), 8'h04);
        cyc(32); chk("d3_pat", PATTERN, 8'hF9); chk("d3_dig", 8'(DIGIT), 8'h08);
        wait_frame();
        p = 0;
        do begin
            @(negedge CLK);
            p++;
        end while (!FRAME && p < 300);
        chk("frame_period", 8'(p), 8'd128);

        wait_digit(4'b0010);
        load(16'hFFFF, 4'b0000, 4'hF);
        wait_digit(4'b0100); chk("tear_d2", PATTERN, 8'hA4);
        wait_digit(4'b1000); chk("tear_d3", PATTERN, 8'hF9);
        wait_frame();
        cyc(3); chk("upd_pat", PATTERN, 8'h8E); chk("upd_dig", 8'(DIGIT), 8'h01);

        load(16'h5555, 4'b0000, 4'hF);
        cyc(10);
        load(16'h6666, 4'b0000, 4'hF);
        wait_frame();
        cyc(3); chk("last_load", PATTERN, 8'h82);

        load(16'h1234, 4'b0000, 4'b1010);
        wait_frame();
        cyc(3);  chk("mask_d0_pat", PATTERN, 8'hFF); chk("mask_d0_dig", 8'(DIGIT), 8'h00);
        cyc(32); chk("mask_d1_pat", PATTERN, 8'hB0); chk("mask_d1_dig", 8'(DIGIT), 8'h02);

`ifdef SEG7_BRIGHTNESS_EN
        begin
            int on, first;
            BRIGHT = 4'd4;
            load(16'h1234, 4'b0000, 4'hF);
            wait_frame();
            on = 0; first = -1;
            for (int i = 1; i <= 32; i++) begin
                @(negedge CLK);
                if (DIGIT != 0) begin
                    on++;
                    if (first < 0) first = i;
                end
            end
            chk("bright4_on", 8'(on), 8'd8);
            chk("bright4_start", 8'(first), 8'd3);
            BRIGHT = 4'd0;
            on = 0;
            for (int i = 0; i < 128; i++) begin
                @(negedge CLK);
                if (DIGIT != 0) on++;
            end
            chk("bright0_on", 8'(on), 8'd0);
            BRIGHT = 4'd15;
        end
`endif

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(39) == 0) load(16'($urandom), 4'($urandom), 4'($urandom));
            else @(negedge CLK);
`ifdef SEG7_BRIGHTNESS_EN
            if ($urandom_range(63) == 0) BRIGHT = 4'($urandom);
`endif
        end

`ifdef SEG7_BRIGHTNESS_EN
        BRIGHT = 4'd15;
`endif
        load(16'h1234, 4'b0000, 4'hF);
        wait_frame();
        wait_digit(4'b0100);
        cyc(5);
        chk("pre_rst_dig", 8'(DIGIT), 8'h04);
        #2 IN_CLR = 1'b0;
        #1;
        chk("async_pat", PATTERN, 8'hFF);
        chk("async_dig", 8'(DIGIT), 8'h00);
        chk("async_frm", 8'(FRAME), 8'h00);
        cyc(3);
        IN_CLR = 1'b1;
        cyc(256);
        chk("post_rst_dark", 8'(DIGIT), 8'h00);
        load(16'h1234, 4'b0000, 4'hF);
        wait_frame();
        p = 0;
        do begin
            @(negedge CLK);
            p++;
        end while (DIGIT == 0 && p < 40);
        chk("first_lit", 8'(DIGIT), 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
